// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, receiver states and divider helper
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  localparam int START_IDX  = 0;
  localparam int PAR_IDX    = 9;
  localparam int STOP_IDX   = 10;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;

  // Bit period in clocks for divider setting div: (div >> 1) + 1, range 1..8.
  function automatic logic [3:0] bit_period(input logic [3:0] div);
    return {1'b0, div[3:1]} + 4'd1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rxd synchronizer chain with falling-edge detect on the synchronized line
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  // Flags the 1->0 step of rx_s in the cycle before it lands, so START begins on rx_s's first low cycle.
  assign fall = rx_s & ~sync_q[SYNC_STAGES-2];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8E1 UART receiver with ack handshake; parity check enabled by UART_RX_PARITY_CHECK_EN
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic                 rx_s, fall, sample;
  logic [3:0]           p_q, cnt_q, half;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 stop_q, commit_q;
`ifdef UART_RX_PARITY_CHECK_EN
  logic                 par_q;
`endif

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (rxd),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign half   = p_q >> 1;
  assign sample = (cnt_q == half);
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (sample) state_d = rx_s ? IDLE : DATA;
      DATA:    if (sample && idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
      PARITY:  if (sample) state_d = STOP;
      STOP:    if (sample) state_d = rx_s ? IDLE : WAIT_HI;
      WAIT_HI: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt restarts on the START edge so cnt==half falls mid-bit for every bit of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q      <= 4'd1;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      stop_q   <= 1'b1;
      commit_q <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      par_q    <= 1'b0;
`endif
    end else begin
      commit_q <= (state_q == STOP) && sample;
      if (state_q == IDLE && fall) begin
        p_q   <= bit_period(n);
        cnt_q <= '0;
      end else if (cnt_q == p_q - 4'd1) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (sample) begin
        case (state_q)
          START: idx_q <= '0;
          DATA: begin
            shift_q[idx_q] <= rx_s;
            idx_q          <= idx_q + 3'd1;
          end
`ifdef UART_RX_PARITY_CHECK_EN
          PARITY: par_q <= rx_s;
`endif
          STOP: stop_q <= rx_s;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_q) begin
      data       <= shift_q;
      frame_err  <= ~stop_q;
`ifdef UART_RX_PARITY_CHECK_EN
      parity_err <= ^{shift_q, par_q};
`else
      parity_err <= 1'b0;
`endif
      // An ack landing with the commit retires the old byte, so only an unacked byte overruns.
      if (data_valid) overrun <= ~data_ack;
      data_valid <= 1'b1;
    end else if (data_valid && data_ack) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver driven by a frame-level transmitter model
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int SYNC = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
  logic       tb_ack = 1'b0, mon_ack = 1'b0, auto_ack = 1'b1;
  logic [3:0] n = 4'd6;
  logic [7:0] data;
  logic       data_valid, data_ack, parity_err, frame_err, overrun, busy;
  int         cyc = 0, start_cyc = 0, dv_cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t       expq[$];

  assign data_ack = tb_ack | mon_ack;

  uart_receiver #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .n         (n),
    .rxd       (rxd),
    .data      (data),
    .data_valid(data_valid),
    .data_ack  (data_ack),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached, got no end of test, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  function automatic int lat(input int p);
    return SYNC + 10 * p + p / 2 + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Transmitter model: builds the 11-bit frame and shifts it out frame[0] first, P clocks per bit.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop, input int low_hold,
                            input int abort_at, input bit push, input bit ov, input bit scramble);
    logic [FRAME_BITS-1:0] fr;
    logic [3:0]            n_keep;
    logic                  pe;
    int                    p, k;
    p = int'(n) / 2 + 1;
    fr[START_IDX] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) fr[START_IDX + 1 + i] = d[i];
    fr[PAR_IDX]  = (^d) ^ flip;
    fr[STOP_IDX] = stop;
`ifdef UART_RX_PARITY_CHECK_EN
    pe = ^fr[PAR_IDX:START_IDX+1];
`else
    pe = 1'b0;
`endif
    if (push) expq.push_back({d, pe, ~stop, ov});
    n_keep    = n;
    k         = 0;
    start_cyc = cyc + 1;
    for (int b = 0; b < FRAME_BITS; b++) begin
      rxd = fr[b];
      for (int c = 0; c < p; c++) begin
        if (abort_at > 0 && k == abort_at) return;
        if (scramble && b == 5 && c == 0) n = 4'($urandom);
        @(negedge clk);
        k++;
      end
    end
    n = n_keep;
    if (!stop) repeat (low_hold) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    repeat (SYNC + 2) @(negedge clk);
    while ((expq.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", expq.size(), 0);
    check("drain_busy", busy, 0);
    expq.delete();
  endtask

  initial begin : monitor
    logic pv;
    exp_t got, prev, e;
    pv   = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      mon_ack = 1'b0;
      got = {data, parity_err, frame_err, overrun};
      if (rst_n && data_valid && (!pv || got != prev)) begin
        dv_cyc = cyc;
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output got data=%h pe=%b fe=%b ov=%b, expected no frame",
                   got.d, got.pe, got.fe, got.ov);
        end else begin
          e = expq.pop_front();
          if (got !== e) begin
            n_bad++;
            $display("FAIL rx_frame got data=%h pe=%b fe=%b ov=%b, expected data=%h pe=%b fe=%b ov=%b",
                     got.d, got.pe, got.fe, got.ov, e.d, e.pe, e.fe, e.ov);
          end
        end
        if (auto_ack) mon_ack = 1'b1;
      end
      pv   = data_valid;
      prev = got;
    end
  end

  initial begin : main
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check("reset_state", {data, data_valid, parity_err, frame_err, overrun, busy}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    n = 4'd6;
    send_frame(8'hA5, 0, 1, 0, 0, 1, 0, 0);
    wait_drain(400);
    check("latency_p4", dv_cyc - start_cyc, lat(4));

    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    check("false_start_busy", busy, 1);
    repeat (SYNC + 2) @(negedge clk);
    check("false_start_idle", busy, 0);
    wait_drain(100);

    send_frame(8'h3C, 1, 1, 0, 0, 1, 0, 0);
    wait_drain(400);
    check("parity_flip_data", data, 8'h3C);

    send_frame(8'h81, 0, 0, 12, 0, 1, 0, 0);
    check("break_busy", busy, 1);
    rxd = 1'b1;
    wait_drain(400);
    send_frame(8'h55, 0, 1, 0, 0, 1, 0, 0);
    wait_drain(400);
    check("after_break_data", data, 8'h55);

    auto_ack = 1'b0;
    send_frame(8'h11, 0, 1, 0, 0, 1, 0, 0);
    send_frame(8'h22, 0, 1, 0, 0, 1, 1, 0);
    wait_drain(400);
    check("overrun_set", overrun, 1);
    tb_ack = 1'b1;
    @(negedge clk);
    tb_ack = 1'b0;
    check("ack_clears_valid", data_valid, 0);
    check("ack_clears_overrun", overrun, 0);
    repeat (4) @(negedge clk);
    send_frame(8'h33, 0, 1, 0, 0, 1, 0, 0);
    wait_drain(400);
    fork
      send_frame(8'h44, 0, 1, 0, 0, 1, 0, 0);
      begin
        repeat (lat(4)) @(negedge clk);
        tb_ack = 1'b1;
        @(negedge clk);
        tb_ack = 1'b0;
      end
    join
    check("same_cycle_valid", data_valid, 1);
    check("same_cycle_overrun", overrun, 0);
    wait_drain(400);
    tb_ack = 1'b1;
    @(negedge clk);
    tb_ack = 1'b0;
    check("final_ack_valid", data_valid, 0);
    auto_ack = 1'b1;

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        n = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(15));
        b = 8'($urandom);
        send_frame(b, $urandom_range(3) == 0, 1, 0, 0, 1, 0, r != 0 && i[0]);
        repeat ((int'(n) / 2 + 1) * (1 + $urandom_range(1))) @(negedge clk);
      end
      n = (r == 0) ? 4'd0 : 4'd15;
      send_frame(8'h96, 0, 1, 0, 0, 1, 0, 0);
      wait_drain(2000);
      check("random_last_latency", dv_cyc - start_cyc, lat(int'(n) / 2 + 1));
    end

    n = 4'd6;
    auto_ack = 1'b0;
    send_frame(8'h5A, 0, 1, 0, 0, 1, 0, 0);
    wait_drain(400);
    send_frame(8'hC3, 0, 1, 0, 16, 0, 0, 0);
    check("busy_mid_frame", busy, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame", {data, data_valid, parity_err, frame_err, overrun, busy}, 0);
    rxd = 1'b1;
    auto_ack = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    b = 8'($urandom);
    send_frame(b, 0, 1, 0, 0, 1, 0, 0);
    wait_drain(400);
    check("post_reset_data", data, b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
